// File: rtl/div_seq_pkg.sv
// div_seq_pkg -- shared CPU defines for the sequential divider.
// Holds only the FSM state encoding and the default operand width.
package div_seq_pkg;

  localparam int unsigned DIV_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_ON     = 2'd2,
    ST_END    = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// div_seq -- multi-cycle restoring divider (DIV / DIVU) for the execute stage.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   start_i       divide request, honoured only in IDLE
//   signed_div_i  1 = signed, 0 = unsigned; sampled with start_i
//   opdata1_i     dividend; sampled with start_i
//   opdata2_i     divisor; sampled with start_i
//   annul_i       cancel any in-flight divide; wins over start_i
//   result_o      {remainder, quotient}; held from END until the next END
//   ready_o       one-cycle result-valid strobe, decoded from state only
//
// Build option:
//   DIV_EARLY_EXIT_EN  when defined, |dividend| < |divisor| (divisor != 0)
//                      skips the iteration and finishes in the next cycle.
//
// state  | meaning
// IDLE   | waiting for start_i
// BYZERO | divisor was zero; result forced to 0
// ON     | one shift-subtract step per cycle, DATA_W cycles
// END    | result_o valid, ready_o high for this cycle
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned DATA_W = DIV_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  div_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;     // partial remainder magnitude
  logic [DATA_W-1:0]     quo_q, quo_d;     // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0]     dvs_q, dvs_d;     // divisor magnitude
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;

  logic [DATA_W-1:0]     mag_a, mag_b;
  logic [DATA_W:0]       shifted, trial;
  logic [DATA_W-1:0]     step_rem, step_quo;
  logic [DATA_W-1:0]     rem_fix, quo_fix;

  // Operand magnitudes; in unsigned mode the raw values are already magnitudes.
  assign mag_a = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign mag_b = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Restoring step. The partial remainder stays below the divisor, so the
  // shifted value fits in DATA_W+1 bits and trial[DATA_W] is a clean borrow.
  assign shifted  = {rem_q, quo_q[DATA_W-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign step_rem = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign step_quo = {quo_q[DATA_W-2:0], ~trial[DATA_W]};

  // Sign fixup on the final step. The most negative dividend divided by -1
  // wraps back onto itself, which is the required result.
  assign quo_fix = neg_quo_q ? -step_quo : step_quo;
  assign rem_fix = neg_rem_q ? -step_rem : step_rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    if (annul_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            neg_quo_d = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i & opdata1_i[DATA_W-1];
            rem_d     = '0;
            quo_d     = mag_a;
            dvs_d     = mag_b;
            cnt_d     = '0;
            if (opdata2_i == '0) begin
              state_d = ST_BYZERO;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (mag_a < mag_b) begin
              // Quotient is zero and the remainder is the dividend, sign included.
              state_d  = ST_END;
              result_d = {opdata1_i, {DATA_W{1'b0}}};
            end
`endif
            else begin
              state_d = ST_ON;
            end
          end
        end
        ST_BYZERO: begin
          state_d  = ST_END;
          result_d = '0;
        end
        ST_ON: begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = ST_END;
            cnt_d    = '0;
            result_d = {rem_fix, quo_fix};
          end
        end
        ST_END: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = (state_q == ST_END);

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int n_vec;
  int n_miss;
  logic [63:0] last_res;

`ifdef DIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 2;
`else
  localparam int LAT_SMALL = 34;
`endif

  div_seq #(.DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the start of a cycle (1 time unit after the edge); that cycle is cycle 1.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, input int exp_cyc, input logic [63:0] exp_res);
    int got_cyc;
    got_cyc      = -1;
    start_i      = 1'b1;
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    next_cycle();
    start_i      = 1'b0;
    signed_div_i = ~sgn;
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    for (int c = 2; c <= 40; c++) begin
      if (ready_o) begin
        got_cyc = c;
        break;
      end
      next_cycle();
    end
    check({tag, "_lat"}, 64'(got_cyc), 64'(exp_cyc));
    check({tag, "_res"}, result_o, exp_res);
    next_cycle();
    check({tag, "_pulse"}, 64'(ready_o), 64'd0);
    check({tag, "_hold"}, result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    logic [7:0] mask;
    int         pulses;
    n_vec        = 0;
    n_miss       = 0;
    last_res     = '0;
    rst          = 1'b1;
    start_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    annul_i      = 1'b0;
    #2;
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    next_cycle();

    run_div("udiv_7_2",   32'd7,          32'd2,          1'b0, 34, 64'h00000001_00000003);
    run_div("sdiv_m7_2",  32'hFFFFFFF9,   32'h00000002,   1'b1, 34, 64'hFFFFFFFF_FFFFFFFD);
    run_div("udiv_big_2", 32'hFFFFFFF9,   32'h00000002,   1'b0, 34, 64'h00000001_7FFFFFFC);
    run_div("sdiv_min_m1",32'h80000000,   32'hFFFFFFFF,   1'b1, 34, 64'h00000000_80000000);
    run_div("sdiv_7_m2",  32'd7,          32'hFFFFFFFE,   1'b1, 34, 64'h00000001_FFFFFFFD);
    run_div("udiv_100_7", 32'd100,        32'd7,          1'b0, 34, 64'h00000002_0000000E);
    run_div("div_by_0",   32'd5,          32'd0,          1'b0, 3,  64'h0);
    run_div("udiv_3_5",   32'd3,          32'd5,          1'b0, LAT_SMALL, 64'h00000003_00000000);

    // start held high across two divide-by-zero operations: END in cycles 3 and 6
    run_div("udiv_9_4", 32'd9, 32'd4, 1'b0, 34, 64'h00000001_00000002);
    mask         = '0;
    start_i      = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = 32'd5;
    opdata2_i    = 32'd0;
    for (int c = 1; c <= 6; c++) begin
      if (ready_o) mask[c] = 1'b1;
      next_cycle();
    end
    start_i = 1'b0;
    check("byzero_held_start", 64'(mask), 64'h48);
    check("byzero_held_res", result_o, 64'h0);
    next_cycle();
    last_res = '0;

    // establish a nonzero result, then annul in ON cycle 10 (overall cycle 11)
    run_div("udiv_50_3", 32'd50, 32'd3, 1'b0, 34, 64'h00000002_00000010);
    pulses       = 0;
    start_i      = 1'b1;
    opdata1_i    = 32'd7;
    opdata2_i    = 32'd2;
    next_cycle();
    start_i = 1'b0;
    for (int c = 2; c <= 11; c++) begin
      if (ready_o) pulses++;
      if (c == 11) annul_i = 1'b1;
      next_cycle();
    end
    annul_i = 1'b0;
    for (int c = 0; c < 36; c++) begin
      if (ready_o) pulses++;
      if (c < 35) next_cycle();
    end
    check("annul_no_ready", 64'(pulses), 64'd0);
    check("annul_keep_res", result_o, last_res);

    // new start directly after an annul completes normally
    pulses = 0;
    start_i   = 1'b1;
    opdata1_i = 32'd7;
    opdata2_i = 32'd2;
    next_cycle();
    start_i = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      if (c == 10) annul_i = 1'b1;
      next_cycle();
    end
    annul_i = 1'b0;
    run_div("after_annul", 32'd100, 32'd7, 1'b0, 34, 64'h00000002_0000000E);

    // asynchronous reset mid-ON
    start_i   = 1'b1;
    opdata1_i = 32'd9;
    opdata2_i = 32'd4;
    next_cycle();
    start_i = 1'b0;
    repeat (12) next_cycle();
    #3 rst = 1'b1;
    #1;
    check("arst_ready", 64'(ready_o), 64'd0);
    check("arst_result", result_o, 64'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      next_cycle();
      if (ready_o) pulses++;
    end
    check("arst_no_ready", 64'(pulses), 64'd0);
    check("arst_result_held", result_o, 64'd0);

    run_div("post_rst_sdiv", 32'hFFFFFF9C, 32'd7, 1'b1, 34, 64'hFFFFFFFE_FFFFFFF2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
